// File: rtl/vc_squash_drop_ctrl_if.sv
// Request/response control bundle for vc_squash_drop_ctrl. The master side is the
// environment (processor, memory and drop unit); the slave side is the controller.
interface vc_squash_drop_ctrl_if #(
    parameter int p_msg_nbits    = 1,
    parameter int p_max_inflight = 4
);
    localparam int c_cnt_nbits = $clog2(p_max_inflight + 1);

    logic                   squash;
    logic [p_msg_nbits-1:0] req_in_msg;
    logic                   req_in_val;
    logic                   req_in_rdy;
    logic [p_msg_nbits-1:0] req_out_msg;
    logic                   req_out_val;
    logic                   req_out_rdy;
    logic                   resp_go;
    logic                   drop;
    logic [c_cnt_nbits-1:0] inflight;
    logic                   err;

    modport master (
        output squash, req_in_msg, req_in_val, req_out_rdy, resp_go,
        input  req_in_rdy, req_out_msg, req_out_val, drop, inflight, err
    );

    modport slave (
        input  squash, req_in_msg, req_in_val, req_out_rdy, resp_go,
        output req_in_rdy, req_out_msg, req_out_val, drop, inflight, err
    );
endinterface

// File: rtl/vc_squash_drop_ctrl.sv
// Tracks outstanding memory requests and, on a pipeline squash, tells the downstream
// drop unit how many in-flight responses to discard. Optional sticky underflow flag
// is built when VC_SQUASH_DROP_CTRL_ERR_EN is defined.
module vc_squash_drop_ctrl #(
    parameter int p_msg_nbits    = 1,
    parameter int p_max_inflight = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_squash_drop_ctrl_if.slave  ctrl
);
    localparam int c_cnt_nbits = $clog2(p_max_inflight + 1);

    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_nbits-1:0] c_cnt_max  = c_cnt_nbits'(p_max_inflight);

    logic [c_cnt_nbits-1:0] inflight_q;
    logic [c_cnt_nbits-1:0] inflight_n;
    logic [c_cnt_nbits-1:0] drop_cnt_q;
    logic [c_cnt_nbits-1:0] drop_cnt_n;
    logic [c_cnt_nbits-1:0] drop_load;
    logic                   full;
    logic                   req_go;
    logic                   resp_take;

    // Full comes from the registered count only, so a same-cycle response never unblocks.
    assign full = (inflight_q == c_cnt_max);

    assign ctrl.req_out_msg = ctrl.req_in_msg;
    assign ctrl.req_out_val = ctrl.req_in_val  && !full && !ctrl.squash;
    assign ctrl.req_in_rdy  = ctrl.req_out_rdy && !full && !ctrl.squash;

    assign req_go    = ctrl.req_out_val && ctrl.req_out_rdy;
    // A response with nothing outstanding is ignored by the counters so they cannot wrap.
    assign resp_take = ctrl.resp_go && (inflight_q != c_cnt_zero);

    always_comb begin
        inflight_n = inflight_q;
        if (req_go && !resp_take) begin
            inflight_n = inflight_q + c_cnt_one;
        end else if (resp_take && !req_go) begin
            inflight_n = inflight_q - c_cnt_one;
        end
    end

    // Squash snapshots what is still owed, less the response retiring this cycle.
    assign drop_load = resp_take ? (inflight_q - c_cnt_one) : inflight_q;

    always_comb begin
        drop_cnt_n = drop_cnt_q;
        if (ctrl.squash) begin
            drop_cnt_n = drop_load;
        end else if (ctrl.resp_go && (drop_cnt_q != c_cnt_zero)) begin
            drop_cnt_n = drop_cnt_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_n;
            drop_cnt_q <= drop_cnt_n;
        end
    end

    assign ctrl.inflight = inflight_q;
    assign ctrl.drop     = (drop_cnt_q != c_cnt_zero);

`ifdef VC_SQUASH_DROP_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (ctrl.resp_go && (inflight_q == c_cnt_zero)) begin
            err_q <= 1'b1;
        end
    end

    assign ctrl.err = err_q;
`else
    assign ctrl.err = 1'b0;
`endif

    a_drop_le_inflight : assert property (@(posedge clk) disable iff (!reset)
        drop_cnt_q <= inflight_q);

endmodule

// File: tb/tb_vc_squash_drop_ctrl.sv
// Directed scoreboard bench for vc_squash_drop_ctrl (p_max_inflight = 4, 8-bit messages).
module tb_vc_squash_drop_ctrl;
    localparam int MSGW = 8;
    localparam int MAXI = 4;
`ifdef VC_SQUASH_DROP_CTRL_ERR_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    typedef struct {
        int    cyc;
        string nm;
        int    infl;
        bit    drop;
        bit    rdy;
        bit    oval;
        bit    err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t            exp_q[$];
    logic [MSGW-1:0] msg_q[$];

    vc_squash_drop_ctrl_if #(.p_msg_nbits(MSGW), .p_max_inflight(MAXI)) bus ();

    vc_squash_drop_ctrl #(.p_msg_nbits(MSGW), .p_max_inflight(MAXI)) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input bit rs, input bit sq, input bit v, input logic [MSGW-1:0] m,
                        input bit ordy, input bit rg, input int ei, input bit ed,
                        input bit er, input bit eo, input bit ee, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rs;
        bus.squash      = sq;
        bus.req_in_val  = v;
        bus.req_in_msg  = m;
        bus.req_out_rdy = ordy;
        bus.resp_go     = rg;
        e.cyc  = cyc;
        e.nm   = nm;
        e.infl = ei;
        e.drop = ed;
        e.rdy  = er;
        e.oval = eo;
        e.err  = ee;
        exp_q.push_back(e);
        if (eo && ordy) msg_q.push_back(m);
    endtask

    // Monitor: checks forwarded messages on every handshake and state on scheduled cycles.
    always @(negedge clk) begin
        if (bus.req_out_val && bus.req_out_rdy) begin
            checks++;
            if (msg_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req cyc=%0d got msg=%02h, required no request", cyc, bus.req_out_msg);
            end else begin
                logic [MSGW-1:0] em;
                em = msg_q.pop_front();
                if (bus.req_out_msg !== em) begin
                    errors++;
                    $display("FAIL req_msg cyc=%0d got %02h required %02h", cyc, bus.req_out_msg, em);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (int'(bus.inflight) != e.infl || bus.drop !== e.drop || bus.req_in_rdy !== e.rdy ||
                bus.req_out_val !== e.oval || bus.err !== e.err) begin
                errors++;
                $display("FAIL %s cyc=%0d got infl=%0d drop=%b rdy=%b oval=%b err=%b required infl=%0d drop=%b rdy=%b oval=%b err=%b",
                         e.nm, cyc, bus.inflight, bus.drop, bus.req_in_rdy, bus.req_out_val, bus.err,
                         e.infl, e.drop, e.rdy, e.oval, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        bus.squash      = 1'b0;
        bus.req_in_val  = 1'b0;
        bus.req_in_msg  = '0;
        bus.req_out_rdy = 1'b1;
        bus.resp_go     = 1'b0;
        repeat (2) @(posedge clk);

        //   rs sq v  msg    ordy rg  infl drop rdy oval err
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   0, "reset_state");
        // fill to the limit, fifth request is held off
        step(1, 0, 1, 8'hA1, 1, 0,   0,   0,   1,  1,   0, "fill_0");
        step(1, 0, 1, 8'hA2, 1, 0,   1,   0,   1,  1,   0, "fill_1");
        step(1, 0, 1, 8'hA3, 1, 0,   2,   0,   1,  1,   0, "fill_2");
        step(1, 0, 1, 8'hA4, 1, 0,   3,   0,   1,  1,   0, "fill_3");
        step(1, 0, 1, 8'hA5, 1, 0,   4,   0,   0,  0,   0, "full_block");
        step(1, 0, 0, 8'h00, 1, 1,   4,   0,   0,  0,   0, "full_resp_same_cycle");
        step(1, 0, 0, 8'h00, 1, 0,   3,   0,   1,  0,   0, "unblock_next");
        step(1, 0, 0, 8'h00, 0, 0,   3,   0,   0,  0,   0, "mem_not_ready");
        // squash with three outstanding
        step(1, 1, 1, 8'hB0, 1, 0,   3,   0,   0,  0,   0, "squash_blocks_req");
        step(1, 0, 0, 8'h00, 1, 0,   3,   1,   1,  0,   0, "drop_after_squash");
        step(1, 0, 0, 8'h00, 1, 1,   3,   1,   1,  0,   0, "drop_resp_1");
        step(1, 0, 0, 8'h00, 1, 1,   2,   1,   1,  0,   0, "drop_resp_2");
        step(1, 0, 0, 8'h00, 1, 1,   1,   1,   1,  0,   0, "drop_resp_3");
        step(1, 0, 1, 8'hC1, 1, 0,   0,   0,   1,  1,   0, "post_squash_req");
        step(1, 0, 0, 8'h00, 1, 1,   1,   0,   1,  0,   0, "post_squash_resp");
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   0, "post_squash_idle");
        // squash coinciding with a response
        step(1, 0, 1, 8'hD1, 1, 0,   0,   0,   1,  1,   0, "two_out_0");
        step(1, 0, 1, 8'hD2, 1, 0,   1,   0,   1,  1,   0, "two_out_1");
        step(1, 1, 0, 8'h00, 1, 1,   2,   0,   0,  0,   0, "squash_and_resp");
        step(1, 0, 0, 8'h00, 1, 0,   1,   1,   1,  0,   0, "drop_cnt_one");
        step(1, 0, 0, 8'h00, 1, 1,   1,   1,   1,  0,   0, "last_drop_resp");
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   0, "drop_cleared");
        // squash with nothing outstanding
        step(1, 1, 1, 8'hE0, 1, 0,   0,   0,   0,  0,   0, "squash_empty");
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   0, "squash_empty_nodrop");
        // response underflow
        step(1, 0, 0, 8'h00, 1, 1,   0,   0,   1,  0,   0, "underflow_resp");
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   E, "underflow_hold");
        step(1, 0, 1, 8'hF1, 1, 0,   0,   0,   1,  1,   E, "err_sticky_0");
        step(1, 0, 1, 8'hF2, 1, 0,   1,   0,   1,  1,   E, "err_sticky_1");
        // reset in the middle of a drop
        step(1, 1, 0, 8'h00, 1, 0,   2,   0,   0,  0,   E, "squash_two");
        step(1, 0, 0, 8'h00, 1, 0,   2,   1,   1,  0,   E, "drop_two");
        step(0, 0, 0, 8'h00, 1, 0,   2,   1,   1,  0,   E, "reset_asserted");
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   0, "after_reset");
        // simultaneous request and response
        step(1, 0, 1, 8'h61, 1, 0,   0,   0,   1,  1,   0, "sim_0");
        step(1, 0, 1, 8'h62, 1, 1,   1,   0,   1,  1,   0, "sim_req_resp");
        step(1, 0, 0, 8'h00, 1, 0,   1,   0,   1,  0,   0, "sim_unchanged");
        step(1, 0, 0, 8'h00, 1, 1,   1,   0,   1,  0,   0, "sim_drain");
        step(1, 0, 0, 8'h00, 1, 0,   0,   0,   1,  0,   0, "sim_empty");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_drain got %0d pending, required 0", exp_q.size());
        end
        checks++;
        if (msg_q.size() != 0) begin
            errors++;
            $display("FAIL msg_drain got %0d pending, required 0", msg_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vc_squash_drop_ctrl.md
VC_SQUASH_DROP_CTRL -- requirements
Module: vc_squash_drop_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter p_msg_nbits, default 1, SHALL set the request message width.
REQ-003 Parameter p_max_inflight, default 4, SHALL set the maximum number of outstanding requests (legal range 1..255).
REQ-004 Localparam c_cnt_nbits SHALL equal $clog2(p_max_inflight+1).
REQ-005 Port clk  input  1  SHALL be the clock.
REQ-006 Port reset  input  1  SHALL be the synchronous, active-low reset.
REQ-007 Port squash  input  1  SHALL be the pipeline squash pulse.
REQ-008 Port req_in_msg  input  p_msg_nbits  SHALL be the request from the processor.
REQ-009 Port req_in_val  input  1  SHALL be the request valid.
REQ-010 Port req_in_rdy  output  1  SHALL be the request ready.
REQ-011 Port req_out_msg  output  p_msg_nbits  SHALL be the request to memory.
REQ-012 Port req_out_val  output  1  SHALL be the memory request valid.
REQ-013 Port req_out_rdy  input  1  SHALL be the memory request ready.
REQ-014 Port resp_go  input  1  SHALL be the response handshake (in_val && in_rdy) at the downstream drop unit's input.
REQ-015 Port drop  output  1  SHALL be the drop request to the downstream drop unit.
REQ-016 Port inflight  output  c_cnt_nbits  SHALL be the registered outstanding-request count.
REQ-017 Port err  output  1  SHALL be the sticky response-underflow flag.

Function
REQ-018 req_out_msg SHALL equal req_in_msg combinationally, with zero latency.
REQ-019 full SHALL be (inflight == p_max_inflight) and SHALL be computed from registered state only.
REQ-020 req_out_val SHALL equal req_in_val && !full && !squash.
REQ-021 req_in_rdy SHALL equal req_out_rdy && !full && !squash.
REQ-022 req_go SHALL equal req_out_val && req_out_rdy.
REQ-023 On each cycle, inflight SHALL update to inflight + req_go - resp_go.
REQ-024 Simultaneous req_go and resp_go SHALL leave inflight unchanged.
REQ-025 A resp_go in a full cycle SHALL NOT unblock requests in that same cycle; requests unblock the next cycle.
REQ-026 drop_cnt is an internal c_cnt_nbits register; drop SHALL equal (drop_cnt != 0).
REQ-027 On squash, drop_cnt SHALL load inflight - resp_go, overriding any current drop_cnt value.
REQ-028 When squash is low, each resp_go with drop_cnt != 0 SHALL decrement drop_cnt by 1.
REQ-029 Requests accepted after a squash cycle SHALL NOT be counted in drop_cnt.
REQ-030 A squash when inflight == 0 SHALL leave drop deasserted.
REQ-031 A resp_go when inflight == 0 SHALL hold inflight and drop_cnt at 0; neither SHALL wrap.
REQ-032 Invariant: drop_cnt SHALL always be less than or equal to inflight.

Reset
REQ-033 While reset == 0 at a clock edge, inflight, drop_cnt and err SHALL clear to 0.
REQ-034 drop SHALL be 0 in the cycle after the reset edge.
REQ-035 A reset that arrives mid-squash or mid-drop SHALL discard all pending drops.
REQ-036 req_in_rdy and req_out_val SHALL follow REQ-020/021 during reset, with full = 0 after the reset edge.

Configuration
REQ-037 Macro VC_SQUASH_DROP_CTRL_ERR_EN defined: err SHALL set on any resp_go when inflight == 0 and stay set until reset.
REQ-038 Macro VC_SQUASH_DROP_CTRL_ERR_EN undefined: err SHALL be tied to 0 and no err register SHALL be built.
REQ-039 All other behaviour SHALL be identical with or without VC_SQUASH_DROP_CTRL_ERR_EN.

Verification
REQ-040 Scenario: p_max_inflight=4, 5 back-to-back requests with req_out_rdy=1 and no responses -> 4 accepted, then req_in_rdy=0 and inflight=4; one resp_go -> rdy returns the following cycle.
REQ-041 Scenario: inflight=3, squash pulse -> drop=1 next cycle; 3 resp_go -> drop falls after the third; a request sent post-squash and its response pass with drop=0.
REQ-042 Scenario: inflight=2, squash and resp_go in the same cycle -> drop_cnt=1, inflight=1; one more resp_go -> drop=0.
REQ-043 Scenario: squash with inflight=0 -> drop stays 0; squash with req_in_val=1 -> req_out_val=0 that cycle.
REQ-044 Scenario: drop_cnt=2, reset=0 for one edge -> inflight=0, drop=0, err=0.
REQ-045 Scenario: ERR_EN defined, resp_go with inflight=0 -> err=1 sticky and inflight remains 0; ERR_EN undefined -> err stays 0.
